// File: rtl/or1200_ic_resp_pkg.sv
// Shared types and constants for the instruction-side responder.
// The FSM state enum, the ITAG encodings and the NOP word returned on errors.
package or1200_ic_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_PREF = 2'd2
    } ic_state_t;

    localparam logic [3:0] ITAG_IDLE = 4'h0;
    localparam logic [3:0] ITAG_NI   = 4'h1;
    localparam logic [3:0] ITAG_BE   = 4'hb;
    localparam logic [3:0] ITAG_PE   = 4'hc;
    localparam logic [3:0] ITAG_TE   = 4'hd;

    localparam logic [31:0] OR1200_NOP = 32'h1541_0000;

endpackage

// File: rtl/or1200_ic_pbuf.sv
// Single-entry sequential prefetch buffer: one word tagged by its word address.
// Invalidate takes priority over a fill in the same cycle.
module or1200_ic_pbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic        inv,
    input  logic [29:0] fill_adr,
    input  logic [31:0] fill_dat,
    input  logic [29:0] cmp_adr,
    output logic        hit,
    output logic [31:0] dat
);

    logic        valid_q;
    logic [29:0] adr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            adr_q   <= 30'd0;
            dat     <= 32'd0;
        end else if (inv) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            adr_q   <= fill_adr;
            dat     <= fill_dat;
        end
    end

    assign hit = valid_q && (adr_q == cmp_adr);

endmodule

// File: rtl/or1200_ic_resp.sv
// Instruction fetch responder: serves icpu requests from the prefetch buffer or
// a classic Wishbone read, with MMU error reporting and a bus watchdog.
//
// Handshake: icpu_cycstb_i is held until a single-cycle icpu_ack_o/icpu_err_o;
// a request is only accepted while neither strobe is high. Wishbone cycles are
// terminated by iwb_ack_i/iwb_err_i while iwb_cyc_o is high, or by the watchdog.
module or1200_ic_resp
    import or1200_ic_resp_pkg::*;
#(
    parameter bit PREFETCH = 1'b1,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icpu_cycstb_i,
    input  logic [31:0] icpu_adr_i,
    input  logic        itlb_miss_i,
    input  logic        immu_fault_i,
    input  logic        flush_i,
    input  logic        inv_i,
    output logic [31:0] icpu_dat_o,
    output logic        icpu_ack_o,
    output logic        icpu_err_o,
    output logic [31:0] icpu_adr_o,
    output logic [3:0]  icpu_tag_o,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic [31:0] iwb_adr_o,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    output ic_state_t   dbg_state
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    ic_state_t   state_q, state_d;
    logic        cyc_d;
    logic [31:0] wadr_d;
    logic [7:0]  tmr_q, tmr_d;
    logic        flushed_q, flushed_d;
    logic        discard_q, discard_d;
    logic        ack_d, err_d;
    logic [31:0] dat_d, radr_d;
    logic [3:0]  tag_d;

    logic        pb_fill, pb_inv, pb_hit;
    logic [31:0] pb_dat;

    logic [31:0] req_wadr;
    logic        accept, term, tmo, discard_now, merge;
    logic        unused_adr_lsb;

    assign req_wadr       = {icpu_adr_i[31:2], 2'b00};
    assign unused_adr_lsb = ^icpu_adr_i[1:0];
    assign accept         = icpu_cycstb_i && !flush_i && !icpu_ack_o && !icpu_err_o;
    assign term           = iwb_cyc_o && (iwb_ack_i || iwb_err_i);
    assign tmo            = iwb_cyc_o && !term && (tmr_q == TMO_LAST);
    assign discard_now    = discard_q || flush_i || inv_i;
    // A demand for the word already being prefetched rides on that bus cycle.
    assign merge          = accept && !itlb_miss_i && !immu_fault_i && !discard_now &&
                            (icpu_adr_i[31:2] == iwb_adr_o[31:2]);

    or1200_ic_pbuf u_pbuf (
        .clk      (clk),
        .rst      (rst),
        .fill     (pb_fill),
        .inv      (pb_inv),
        .fill_adr (iwb_adr_o[31:2]),
        .fill_dat (iwb_dat_i),
        .cmp_adr  (icpu_adr_i[31:2]),
        .hit      (pb_hit),
        .dat      (pb_dat)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = iwb_cyc_o;
        wadr_d    = iwb_adr_o;
        tmr_d     = tmr_q;
        flushed_d = flushed_q;
        discard_d = discard_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = icpu_dat_o;
        radr_d    = icpu_adr_o;
        tag_d     = icpu_tag_o;
        pb_fill   = 1'b0;
        pb_inv    = inv_i;

        if (iwb_cyc_o && !term) tmr_d = tmr_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    radr_d = req_wadr;
                    if (itlb_miss_i) begin
                        err_d = 1'b1;
                        tag_d = ITAG_TE;
                        dat_d = OR1200_NOP;
                    end else if (immu_fault_i) begin
                        err_d = 1'b1;
                        tag_d = ITAG_PE;
                        dat_d = OR1200_NOP;
                    end else if (pb_hit && !inv_i) begin
                        ack_d = 1'b1;
                        tag_d = ITAG_NI;
                        dat_d = pb_dat;
                        if (PREFETCH) begin
                            state_d   = ST_PREF;
                            wadr_d    = req_wadr + 32'd4;
                            discard_d = 1'b0;
                        end
                    end else begin
                        state_d   = ST_BUS;
                        cyc_d     = 1'b1;
                        wadr_d    = req_wadr;
                        tmr_d     = 8'd0;
                        flushed_d = 1'b0;
                    end
                end
            end

            ST_BUS: begin
                if (flush_i) begin
                    flushed_d = 1'b1;
                    pb_inv    = 1'b1;
                end
                if (iwb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (!flushed_q && !flush_i) begin
                        ack_d  = 1'b1;
                        tag_d  = ITAG_NI;
                        dat_d  = iwb_dat_i;
                        radr_d = iwb_adr_o;
                        if (PREFETCH) begin
                            state_d   = ST_PREF;
                            wadr_d    = iwb_adr_o + 32'd4;
                            discard_d = 1'b0;
                        end
                    end
                end else if (iwb_err_i || tmo) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    pb_inv  = 1'b1;
                    if (!flushed_q && !flush_i) begin
                        err_d  = 1'b1;
                        tag_d  = ITAG_BE;
                        dat_d  = OR1200_NOP;
                        radr_d = iwb_adr_o;
                    end
                end
            end

            ST_PREF: begin
                if (flush_i || inv_i) discard_d = 1'b1;
                // The prefetch cycle is launched one cycle after entering PREF.
                if (!iwb_cyc_o) begin
                    cyc_d = 1'b1;
                    tmr_d = 8'd0;
                end else if (iwb_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    pb_fill = !discard_now;
                    if (merge) begin
                        ack_d  = 1'b1;
                        tag_d  = ITAG_NI;
                        dat_d  = iwb_dat_i;
                        radr_d = iwb_adr_o;
                    end
                end else if (iwb_err_i || tmo) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    pb_inv  = 1'b1;
                    if (merge) begin
                        err_d  = 1'b1;
                        tag_d  = ITAG_BE;
                        dat_d  = OR1200_NOP;
                        radr_d = iwb_adr_o;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            iwb_cyc_o  <= 1'b0;
            iwb_adr_o  <= 32'd0;
            tmr_q      <= 8'd0;
            flushed_q  <= 1'b0;
            discard_q  <= 1'b0;
            icpu_ack_o <= 1'b0;
            icpu_err_o <= 1'b0;
            icpu_dat_o <= 32'd0;
            icpu_adr_o <= 32'd0;
            icpu_tag_o <= ITAG_IDLE;
        end else begin
            state_q    <= state_d;
            iwb_cyc_o  <= cyc_d;
            iwb_adr_o  <= wadr_d;
            tmr_q      <= tmr_d;
            flushed_q  <= flushed_d;
            discard_q  <= discard_d;
            icpu_ack_o <= ack_d;
            icpu_err_o <= err_d;
            icpu_dat_o <= dat_d;
            icpu_adr_o <= radr_d;
            icpu_tag_o <= tag_d;
        end
    end

    assign iwb_stb_o = iwb_cyc_o;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_or1200_ic_resp.sv
// Directed bench for or1200_ic_resp: stimulus pushes expected icpu responses,
// a negedge monitor pops and compares them; bus timing is checked inline.
module tb_or1200_ic_resp;
    import or1200_ic_resp_pkg::*;

    localparam int W = 70;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icpu_cycstb_i = 1'b0;
    logic [31:0] icpu_adr_i = 32'd0;
    logic        itlb_miss_i = 1'b0;
    logic        immu_fault_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        inv_i = 1'b0;
    logic [31:0] icpu_dat_o;
    logic        icpu_ack_o;
    logic        icpu_err_o;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;
    logic        iwb_cyc_o;
    logic        iwb_stb_o;
    logic [31:0] iwb_adr_o;
    logic [31:0] iwb_dat_i = 32'd0;
    logic        iwb_ack_i = 1'b0;
    logic        iwb_err_i = 1'b0;
    ic_state_t   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    or1200_ic_resp #(.PREFETCH(1'b1), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .icpu_cycstb_i (icpu_cycstb_i),
        .icpu_adr_i    (icpu_adr_i),
        .itlb_miss_i   (itlb_miss_i),
        .immu_fault_i  (immu_fault_i),
        .flush_i       (flush_i),
        .inv_i         (inv_i),
        .icpu_dat_o    (icpu_dat_o),
        .icpu_ack_o    (icpu_ack_o),
        .icpu_err_o    (icpu_err_o),
        .icpu_adr_o    (icpu_adr_o),
        .icpu_tag_o    (icpu_tag_o),
        .iwb_cyc_o     (iwb_cyc_o),
        .iwb_stb_o     (iwb_stb_o),
        .iwb_adr_o     (iwb_adr_o),
        .iwb_dat_i     (iwb_dat_i),
        .iwb_ack_i     (iwb_ack_i),
        .iwb_err_i     (iwb_err_i),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic err, input logic [3:0] tag,
                               input logic [31:0] adr, input logic [31:0] dat);
        exp_q.push_back({err, ~err, tag, adr, dat});
    endtask

    task automatic request(input logic [31:0] adr);
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = adr;
    endtask

    task automatic idle_inputs();
        icpu_cycstb_i = 1'b0;
        itlb_miss_i   = 1'b0;
        immu_fault_i  = 1'b0;
        iwb_ack_i     = 1'b0;
        iwb_err_i     = 1'b0;
        flush_i       = 1'b0;
        inv_i         = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (icpu_ack_o || icpu_err_o)) begin
            logic [W-1:0] got;
            logic [W-1:0] e;
            got = {icpu_err_o, icpu_ack_o, icpu_tag_o, icpu_adr_o, icpu_dat_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL resp got %0h expected %0h", got, e);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(icpu_ack_o), 32'd0);
        chk("rst_err", 32'(icpu_err_o), 32'd0);
        chk("rst_tag", 32'(icpu_tag_o), 32'(ITAG_IDLE));
        chk("rst_dat", icpu_dat_o, 32'd0);
        chk("rst_adr", icpu_adr_o, 32'd0);
        chk("rst_cyc", 32'(iwb_cyc_o), 32'd0);
        chk("rst_iwb_adr", iwb_adr_o, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // miss at 0x100
        request(32'h100);
        tick();
        chk("miss_cyc", 32'(iwb_cyc_o), 32'd1);
        chk("miss_stb", 32'(iwb_stb_o), 32'd1);
        chk("miss_iwb_adr", iwb_adr_o, 32'h100);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h1234_5678;
        expect_resp(1'b0, ITAG_NI, 32'h100, 32'h1234_5678);
        tick();
        chk("miss_cyc_drop", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();
        chk("pref104_cyc", 32'(iwb_cyc_o), 32'd1);
        chk("pref104_adr", iwb_adr_o, 32'h104);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0000_aaaa;
        tick();
        chk("pref104_done", 32'(dbg_state), 32'(ST_IDLE));
        idle_inputs();

        // sequential hit at 0x104, then merge with prefetch of 0x108
        request(32'h104);
        expect_resp(1'b0, ITAG_NI, 32'h104, 32'h0000_aaaa);
        tick();
        chk("hit_no_cyc", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();
        chk("pref108_cyc", 32'(iwb_cyc_o), 32'd1);
        chk("pref108_adr", iwb_adr_o, 32'h108);
        request(32'h108);
        tick();
        chk("merge_wait", 32'(icpu_ack_o), 32'd0);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'hbbbb_0108;
        expect_resp(1'b0, ITAG_NI, 32'h108, 32'hbbbb_0108);
        tick();
        chk("merge_cyc_drop", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();

        // MMU errors
        request(32'h200);
        itlb_miss_i = 1'b1;
        expect_resp(1'b1, ITAG_TE, 32'h200, 32'h1541_0000);
        tick();
        chk("itlb_no_cyc", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();
        request(32'h204);
        immu_fault_i = 1'b1;
        expect_resp(1'b1, ITAG_PE, 32'h204, 32'h1541_0000);
        tick();
        chk("fault_no_cyc", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();

        // bus error on demand
        request(32'h300);
        tick();
        chk("berr_cyc", 32'(iwb_cyc_o), 32'd1);
        iwb_err_i = 1'b1;
        expect_resp(1'b1, ITAG_BE, 32'h300, 32'h1541_0000);
        tick();
        chk("berr_cyc_drop", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();

        // watchdog with TIMEOUT=4: cyc high for exactly 4 cycles
        request(32'h400);
        tick();
        chk("tmo_cyc_0", 32'(iwb_cyc_o), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("tmo_cyc_%0d", i), 32'(iwb_cyc_o), 32'd1);
        end
        expect_resp(1'b1, ITAG_BE, 32'h400, 32'h1541_0000);
        tick();
        chk("tmo_cyc_drop", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();
        tick();

        // flush in BUS with ack in the same cycle
        request(32'h500);
        tick();
        chk("flush_cyc", 32'(iwb_cyc_o), 32'd1);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'hdead_0500;
        flush_i   = 1'b1;
        tick();
        chk("flush_no_ack", 32'(icpu_ack_o), 32'd0);
        chk("flush_cyc_drop", 32'(iwb_cyc_o), 32'd0);
        chk("flush_idle", 32'(dbg_state), 32'(ST_IDLE));
        iwb_ack_i = 1'b0;
        flush_i   = 1'b0;
        tick();
        chk("reissue_cyc", 32'(iwb_cyc_o), 32'd1);
        chk("reissue_adr", iwb_adr_o, 32'h500);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0000_5500;
        expect_resp(1'b0, ITAG_NI, 32'h500, 32'h0000_5500);
        tick();
        idle_inputs();
        tick();
        chk("pref504_adr", iwb_adr_o, 32'h504);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0000_5504;
        tick();
        idle_inputs();

        // wrap: fetch at 0xFFFF_FFFC prefetches 0x0
        request(32'hffff_fffc);
        tick();
        chk("wrap_adr", iwb_adr_o, 32'hffff_fffc);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'hcafe_0001;
        expect_resp(1'b0, ITAG_NI, 32'hffff_fffc, 32'hcafe_0001);
        tick();
        idle_inputs();
        tick();
        chk("wrap_pref_cyc", 32'(iwb_cyc_o), 32'd1);
        chk("wrap_pref_adr", iwb_adr_o, 32'h0);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0000_0da7;
        tick();
        idle_inputs();
        request(32'h0);
        expect_resp(1'b0, ITAG_NI, 32'h0, 32'h0000_0da7);
        tick();
        chk("wrap_hit_no_cyc", 32'(iwb_cyc_o), 32'd0);
        idle_inputs();

        // invalidate during prefetch of 0x4 discards its data
        tick();
        chk("pref4_adr", iwb_adr_o, 32'h4);
        inv_i = 1'b1;
        tick();
        inv_i     = 1'b0;
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0000_4444;
        tick();
        idle_inputs();
        request(32'h4);
        tick();
        chk("inv_miss_cyc", 32'(iwb_cyc_o), 32'd1);

        // reset mid-cycle, late ack ignored
        rst = 1'b1;
        tick();
        chk("midrst_cyc", 32'(iwb_cyc_o), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        icpu_cycstb_i = 1'b0;
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0bad_0bad;
        tick();
        chk("late_ack_ignored", 32'(icpu_ack_o), 32'd0);
        chk("late_ack_state", 32'(dbg_state), 32'(ST_IDLE));
        idle_inputs();
        tick();
        tick();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or1200_ic_resp.md
# or1200_ic_resp

Instruction-side responder that serves fetch requests from the IF/genpc stage over the icpu interface. It returns instructions with icpu_ack, or errors with icpu_err plus an ITAG. Misses are fetched over a classic Wishbone instruction bus. A single-word sequential prefetch buffer lets back-to-back sequential fetches complete in one cycle.

## Interface
- PREFETCH, 1: enable sequential prefetch of (last address + 4) after each demand bus fetch.
- TIMEOUT, 255: bus-cycle watchdog limit in cycles; 8-bit counter.
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- icpu_cycstb_i  in  1  fetch request; held until ack/err
- icpu_adr_i  in  32  request address; bits [1:0] ignored
- itlb_miss_i  in  1  ITLB miss for the current request
- immu_fault_i  in  1  IMMU page fault for the current request
- flush_i  in  1  pipeline flush; abandon the outstanding demand
- inv_i  in  1  invalidate the prefetch buffer
- icpu_dat_o  out  32  instruction; NOP 32'h1541_0000 on err
- icpu_ack_o  out  1  one-cycle response strobe
- icpu_err_o  out  1  one-cycle error strobe
- icpu_adr_o  out  32  word-aligned address of the returned word
- icpu_tag_o  out  4  ITAG values: IDLE 4'h0, NI 4'h1, BE 4'hb, PE 4'hc, TE 4'hd
- iwb_cyc_o / iwb_stb_o  out  1  Wishbone cycle/strobe (driven identically)
- iwb_adr_o  out  32  Wishbone address
- iwb_dat_i  in  32  Wishbone read data
- iwb_ack_i / iwb_err_i  in  1  Wishbone termination

## Operation
- FSM states: IDLE, BUS (demand outstanding), PREF (prefetch outstanding). All outputs are registered.
- IDLE, with cycstb and no flush, and no ack/err being driven this cycle:
  - itlb_miss_i → err, tag TE; no bus access.
  - Else immu_fault_i → err, tag PE.
  - Else buffer hit (pbuf_valid, and pbuf_adr == adr[31:2]) → ack with buffered data, tag NI. If PREFETCH, then enter PREF for adr+4.
  - Else start a bus cycle at {adr[31:2],2'b00} and enter BUS.
- BUS:
  - iwb_ack_i → ack with iwb_dat_i, tag NI. Go to PREF (adr+4) if PREFETCH, else IDLE.
  - iwb_err_i or timeout → err, tag BE. Drop cyc, go to IDLE, pbuf invalid.
- PREF:
  - iwb_ack_i → fill pbuf (valid, adr, data), go to IDLE.
  - iwb_err_i or timeout → pbuf invalid, go to IDLE, no icpu response.
  - A pending demand whose address equals the prefetch address is merged: it is answered from iwb_dat_i on ack, or with BE on err/timeout.
  - Other demands wait for IDLE.
- Flush:
  - In BUS, the bus cycle runs to termination but no icpu response is issued; pbuf is invalidated.
  - In PREF, the bus cycle completes and its data is discarded.
  - In IDLE, requests are ignored during the flush cycle.
- inv_i clears pbuf_valid; it also discards an in-flight prefetch result.
- Prefetch address wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: all strobes 0, tag IDLE, dat 0, adr 0, iwb_adr 0, state IDLE, pbuf invalid, timeout counter 0.
- Hit / MMU error: request sampled in cycle N, ack/err high in cycle N+1.
- Miss: cyc/stb high from N+1; iwb_ack_i in cycle M; icpu_ack_o high in M+1; cyc low in M+1.
- ack/err are single-cycle. In the response cycle, cycstb still shows the old request and is not re-accepted.
- Timeout: counter starts at 0 when cyc rises and increments each cycle without termination. Reaching TIMEOUT-1 drops cyc on the next edge and acts as bus error.
- Termination wins over timeout in the same cycle. Flush wins over termination for the icpu response.
- Reset mid-cycle drops cyc at the next edge; the late ack is ignored.

## Structure
- Package or1200_ic_resp_pkg holds:
  - the state enum;
  - ITAG constants (IDLE/NI/BE/PE/TE);
  - the NOP constant 32'h1541_0000.
- Sub-module or1200_ic_pbuf: single-entry buffer with valid, adr[31:2], data, fill, invalidate and hit compare.
- FSM, watchdog and output registers stay in the top module.

## Test plan
- Reset, then miss at 32'h100: cyc rises at N+1; iwb_ack_i with 32'h1234_5678 → one-cycle ack with dat 32'h1234_5678, adr 32'h100, tag 4'h1.
- Sequential hit, PREFETCH=1: after the 32'h100 fetch and prefetch complete, request 32'h104 → ack one cycle later with no bus cycle. A new prefetch of 32'h108 starts.
- MMU errors: itlb_miss_i → err, tag 4'hd, dat 32'h1541_0000, no cyc. immu_fault_i alone → tag 4'hc.
- Bus error and timeout:
  - iwb_err_i on a demand → err, tag 4'hb.
  - No ack with TIMEOUT=4 → cyc drops after 4 cycles, err with tag 4'hb.
- Flush during BUS, with ack arriving in the same cycle → no icpu ack; pbuf invalid; the next request to the same address causes a new bus cycle.
- Merge and wrap:
  - Demand 32'h108 issued during the PREF of 32'h108 → answered in the cycle after iwb_ack_i.
  - Fetch at 32'hFFFF_FFFC → prefetch address 32'h0000_0000.
